wb_cmd_master: RTL

Wishbone classic single-cycle bus master that converts a valid/ready command stream into one Wishbone read or write per command and returns a response with completion status. It is the initiator counterpart to the platform's register slaves (syscon and peers). It sits between a local controller (debug bridge, boot sequencer) and the system Wishbone interconnect. It handles slave wait states, retry requests and error terminations, and has an optional bus-hang watchdog.

---
 rtl/wb_cmd_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns a valid/ready command stream into one Wishbone classic cycle per command.
// Optional bus-hang watchdog is compiled in when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 256,
    parameter int MAX_RETRY = 3
) (
    input  logic          wb_clk,
    input  logic          wb_rst,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_dat,
    input  logic [3:0]    cmd_sel,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dat,
    output logic [1:0]    rsp_status,

    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t     r_state;
    logic [3:0] r_retryCnt;
    logic       r_gapCnt;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [1:0]  ST_TMO    = 2'b11;
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_wdog;
`endif

    assign cmd_ready = (r_state == IDLE);

    // Terminations are only looked at in BUS, so stale acks from unqualified slaves are harmless.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state    <= IDLE;
            r_retryCnt <= '0;
            r_gapCnt   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            r_wdog     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_we_o    <= cmd_we;
                        wb_adr_o   <= cmd_adr;
                        wb_dat_o   <= cmd_dat;
                        wb_sel_o   <= cmd_sel;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        r_retryCnt <= '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        r_wdog     <= '0;
`endif
                        r_state    <= BUS;
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        rsp_dat    <= wb_we_o ? '0 : wb_dat_i;
                        rsp_status <= ST_OK;
                        rsp_valid  <= 1'b1;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        r_state    <= RSP;
                    end else if (wb_err_i) begin
                        rsp_dat    <= '0;
                        rsp_status <= ST_ERR;
                        rsp_valid  <= 1'b1;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        r_state    <= RSP;
                    end else if (wb_rty_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (r_retryCnt == RETRY_LIMIT) begin
                            rsp_dat    <= '0;
                            rsp_status <= ST_RTY;
                            rsp_valid  <= 1'b1;
                            r_state    <= RSP;
                        end else begin
                            r_retryCnt <= r_retryCnt + 4'd1;
                            r_gapCnt   <= 1'b0;
                            r_state    <= GAP;
                        end
                    end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    else if (r_wdog == WDOG_LAST) begin
                        rsp_dat    <= '0;
                        rsp_status <= ST_TMO;
                        rsp_valid  <= 1'b1;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        r_state    <= RSP;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
`endif
                end
                // Two idle cycles give a registered slave time to drop its retry before re-issuing.
                GAP: begin
                    if (r_gapCnt) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                        r_wdog   <= '0;
`endif
                        r_state  <= BUS;
                    end else begin
                        r_gapCnt <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
